zbreak: RTL and testbench
=========================

Name: zbreak

Overview:
- Breakpoint/single-step request generator for the Z80 NMI path; the initiator side of the immediate-NMI interface.
- Snoops Z80 opcode fetches (M1) and compares fetch addresses with four programmable breakpoints and a step counter.
- On a match, raises imm_nmi, a level that the NMI generator rising-edge detects, and holds it until the CPU is in NMI mode.
- Suppresses all detection while in_nmi=1, so the monitor code never self-triggers.

Parameters:
- FIRE_TMO, 63: maximum zpos ticks imm_nmi stays high without in_nmi asserting; range 1..255.

Ports:
- rst_n  in  1  asynchronous reset, active-low.
- fclk  in  1  system clock.
- zpos  in  1  one-fclk strobe at Z80 clock rising edge.
- zneg  in  1  one-fclk strobe at Z80 clock falling edge.
- m1_n  in  1  Z80 M1.
- mreq_n  in  1  Z80 MREQ.
- a  in  16  Z80 address bus.
- wr_stb  in  1  one-fclk config write strobe.
- wr_addr  in  4  config register index.
- wr_data  in  8  config write data.
- in_nmi  in  1  NMI-mode flag from the NMI generator.
- imm_nmi  out  1  immediate NMI request, level.
- hit_valid  out  1  a breakpoint or step fired since the last status clear.
- hit_idx  out  2  index of the lowest-numbered matching breakpoint.
- hit_step  out  1  the step counter caused, or co-caused, the fire.
- fire_tmo  out  1  the last fire timed out without in_nmi.

Behaviour:
- Reset: all config registers 0, state IDLE, imm_nmi=0, hit_valid=0, hit_idx=0, hit_step=0, fire_tmo=0.
- Config registers (written on wr_stb):
  - wr_addr 0..7: bp[n] address low byte (index 2n) and high byte (index 2n+1).
  - wr_addr 8: [3:0] enable mask, [7:4] one-shot mask.
  - wr_addr 9: step count N (8 bit).
  - wr_addr 10: any write clears hit_valid, hit_step and fire_tmo.
  - wr_addr 11..15: ignored.
- M1 detection:
  - m1_n is sampled on zpos, mreq_n on zneg.
  - m1_seen = both sampled values low.
  - m1_edge = m1_seen & ~m1_seen delayed one fclk; exactly one pulse per opcode fetch.
  - On m1_edge, a is compared combinationally with the register values current in that same fclk. A write coinciding with m1_edge takes effect for the next fetch.
- Match: match[n] = enable[n] & (a == bp[n]).
- Step counter:
  - On m1_edge in WATCH with N != 0, N decrements.
  - The transition 1 -> 0 is a step hit.
  - N=0 means stepping is off.
- States:
  - IDLE: enable mask = 0 and N = 0. Leaves to WATCH as soon as either becomes nonzero.
  - WATCH: on m1_edge with in_nmi=0 and (any match or step hit), go to FIRE next fclk. In the same fclk:
    - hit_valid = 1.
    - hit_idx = lowest matching n; unchanged if step-only.
    - hit_step = step hit.
    - Enable bits of matching breakpoints whose one-shot bit is set are cleared.
  - FIRE: imm_nmi = 1; a prescaler counts zpos.
    - in_nmi = 1 -> WAIT_EXIT, imm_nmi = 0 next fclk.
    - Count reaches FIRE_TMO without in_nmi -> fire_tmo = 1, imm_nmi = 0, go to WATCH.
    - The minimum imm_nmi high time is 2 fclk, even if in_nmi is already 1 (e.g. in_nmi rising in the same cycle).
  - WAIT_EXIT: no detection, and the step counter is frozen. When in_nmi = 0, return to WATCH, or to IDLE if the enable mask and N are both 0.
- in_nmi = 1 in any state blocks new fires. A write to N during NMI is accepted, and stepping counts only fetches outside NMI.
- Address compare is the full 16 bits; there is no page qualification.
- Step counter wrap: none. It stops at 0.
- Async reset mid-FIRE drops imm_nmi immediately.

Test Plan:
- Set bp0 = 0x1234, enable = 0x01; fetch at 0x1233 then 0x1234 -> imm_nmi rises 1 fclk after the 0x1234 m1_edge; hit_idx = 0, hit_valid = 1; imm_nmi falls after in_nmi = 1.
- bp1 = bp2 = 0x8000, enables 0x06, one-shot 0x02; fetch 0x8000 -> hit_idx = 1; enable mask reads back 0x04; after NMI exit, next fetch of 0x8000 fires with hit_idx = 2.
- N = 3, no enables; fetch three opcodes -> fire on the third m1_edge, hit_step = 1, N = 0; a fourth fetch does not fire.
- Fire with in_nmi held 0 -> imm_nmi high for exactly FIRE_TMO zpos ticks, then fire_tmo = 1, state WATCH; a write to index 10 clears fire_tmo.
- in_nmi = 1 with bp0 = 0x0066 enabled, fetch 0x0066 -> no fire. Write N = 5 in the same fclk as an m1_edge -> that fetch does not decrement.
- Assert rst_n = 0 during FIRE -> imm_nmi = 0 immediately, all registers 0, and no fire after release.

Source files
------------

// File: rtl/zbreak.sv
// zbreak: breakpoint / single-step NMI request generator.
// Snoops Z80 M1 fetches and raises imm_nmi until the CPU enters NMI.
module zbreak #(
  parameter int unsigned FIRE_TMO = 63
) (
  input  logic        rst_n,
  input  logic        fclk,
  input  logic        zpos,
  input  logic        zneg,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic [15:0] a,
  input  logic        wr_stb,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        in_nmi,
  output logic        imm_nmi,
  output logic        hit_valid,
  output logic [1:0]  hit_idx,
  output logic        hit_step,
  output logic        fire_tmo
);

  typedef enum logic [1:0] {
    IDLE,
    WATCH,
    FIRE,
    WAIT_EXIT
  } state_t;

  localparam logic [7:0] TMO    = 8'(FIRE_TMO);
  localparam logic [7:0] TMO_M1 = 8'(FIRE_TMO - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] bp [4];
  logic [3:0]  en;
  logic [3:0]  os;
  logic [7:0]  n;
  logic        m1_s;
  logic        mreq_s;
  logic        seen_d;
  logic [7:0]  cnt;
  logic        armed;

  logic        seen;
  logic        m1_edge;
  logic        wr_bp;
  logic        wr_cfg;
  logic        wr_n;
  logic        wr_clr;
  logic [3:0]  match;
  logic [1:0]  low_idx;
  logic        active;
  logic        step_hit;
  logic        fire;
  logic        tmo_now;
  logic        tmo_exit;
  logic        cfg_zero;

  assign seen    = ~m1_s & ~mreq_s;
  assign m1_edge = seen & ~seen_d;

  assign wr_bp  = wr_stb & ~wr_addr[3];
  assign wr_cfg = wr_stb & (wr_addr == 4'd8);
  assign wr_n   = wr_stb & (wr_addr == 4'd9);
  assign wr_clr = wr_stb & (wr_addr == 4'd10);

  assign cfg_zero = (en == 4'd0) && (n == 8'd0);

  // Detection only counts fetches in WATCH outside NMI mode.
  assign active   = (state == WATCH) & m1_edge & ~in_nmi;
  assign step_hit = active & (n == 8'd1);
  assign fire     = active & ((|match) | step_hit);

  // Timeout once the prescaler reaches FIRE_TMO zpos ticks.
  assign tmo_now = (zpos && cnt == TMO_M1) || (cnt >= TMO);
  assign tmo_exit = (state == FIRE) & armed & ~in_nmi & tmo_now;

  // Full 16-bit compare against each enabled breakpoint.
  always_comb begin
    match = '0;
    for (int i = 0; i < 4; i++) begin
      match[i] = en[i] & (a == bp[i]);
    end
  end

  // Lowest-numbered match wins; keep old index when step-only.
  always_comb begin
    low_idx = hit_idx;
    priority case (1'b1)
      match[0]: low_idx = 2'd0;
      match[1]: low_idx = 2'd1;
      match[2]: low_idx = 2'd2;
      match[3]: low_idx = 2'd3;
      default:  low_idx = hit_idx;
    endcase
  end

  // Next-state logic; armed enforces a 2-fclk minimum pulse.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!cfg_zero) state_nx = WATCH;
      end
      WATCH: begin
        if (fire) state_nx = FIRE;
      end
      FIRE: begin
        if (armed && in_nmi) state_nx = WAIT_EXIT;
        else if (tmo_exit) state_nx = WATCH;
      end
      WAIT_EXIT: begin
        if (!in_nmi) state_nx = cfg_zero ? IDLE : WATCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sample M1 on the rising and MREQ on the falling Z80 edge.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      m1_s   <= 1'b1;
      mreq_s <= 1'b1;
      seen_d <= 1'b0;
    end else begin
      if (zpos) m1_s <= m1_n;
      if (zneg) mreq_s <= mreq_n;
      seen_d <= seen;
    end
  end

  // State register, registered request level and fire prescaler.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      imm_nmi <= 1'b0;
      armed   <= 1'b0;
      cnt     <= 8'd0;
    end else begin
      state   <= state_nx;
      imm_nmi <= (state_nx == FIRE);
      armed   <= (state == FIRE);
      if (state != FIRE) cnt <= 8'd0;
      else if (zpos && cnt < TMO) cnt <= cnt + 8'd1;
    end
  end

  // Breakpoint address registers.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) bp[i] <= 16'd0;
    end else if (wr_bp) begin
      if (wr_addr[0]) bp[wr_addr[2:1]][15:8] <= wr_data;
      else bp[wr_addr[2:1]][7:0] <= wr_data;
    end
  end

  // Enable/one-shot masks and step counter; writes win.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      en <= 4'd0;
      os <= 4'd0;
      n  <= 8'd0;
    end else begin
      if (wr_cfg) begin
        en <= wr_data[3:0];
        os <= wr_data[7:4];
      end else if (fire) begin
        en <= en & ~(match & os);
      end
      if (wr_n) n <= wr_data;
      else if (active && n != 8'd0) n <= n - 8'd1;
    end
  end

  // Sticky status; a new fire has priority over a clear.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid <= 1'b0;
      hit_idx   <= 2'd0;
      hit_step  <= 1'b0;
      fire_tmo  <= 1'b0;
    end else begin
      if (fire) begin
        hit_valid <= 1'b1;
        hit_idx   <= low_idx;
        hit_step  <= step_hit;
      end else if (wr_clr) begin
        hit_valid <= 1'b0;
        hit_step  <= 1'b0;
      end
      if (tmo_exit) fire_tmo <= 1'b1;
      else if (wr_clr) fire_tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zbreak.sv
// tb_zbreak: scenario tasks plus randomized fetches
// checked against a behavioural breakpoint model.
module tb_zbreak;

  localparam int TMO = 63;

  logic        rst_n;
  logic        fclk;
  logic        zpos;
  logic        zneg;
  logic        m1_n;
  logic        mreq_n;
  logic [15:0] a;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        in_nmi;
  logic        imm_nmi;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic        hit_step;
  logic        fire_tmo;

  int n_checks;
  int n_fail;
  int zp_hi;

  logic [15:0] m_bp [4];
  logic [3:0]  m_en;
  logic [3:0]  m_os;
  int          m_n;
  logic        m_hv;
  logic [1:0]  m_idx;
  logic        m_step;
  logic        m_tmo;

  zbreak #(.FIRE_TMO(TMO)) dut (
    .rst_n(rst_n),
    .fclk(fclk),
    .zpos(zpos),
    .zneg(zneg),
    .m1_n(m1_n),
    .mreq_n(mreq_n),
    .a(a),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .in_nmi(in_nmi),
    .imm_nmi(imm_nmi),
    .hit_valid(hit_valid),
    .hit_idx(hit_idx),
    .hit_step(hit_step),
    .fire_tmo(fire_tmo)
  );

  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_bp[i] = 16'd0;
    m_en = 0; m_os = 0; m_n = 0;
    m_hv = 0; m_idx = 0; m_step = 0; m_tmo = 0;
  endfunction

  function automatic void model_wr(logic [3:0] ad, logic [7:0] d);
    if (ad < 8) begin
      if (ad[0]) m_bp[ad / 2] = {d, m_bp[ad / 2][7:0]};
      else m_bp[ad / 2] = {m_bp[ad / 2][15:8], d};
    end else if (ad == 8) begin
      m_en = d[3:0];
      m_os = d[7:4];
    end else if (ad == 9) begin
      m_n = d;
    end else if (ad == 10) begin
      m_hv = 0; m_step = 0; m_tmo = 0;
    end
  endfunction

  // Predict whether an opcode fetch at ad raises a request.
  function automatic bit model_fetch(logic [15:0] ad, bit nmi);
    logic [3:0] m;
    bit st;
    bit f;
    if (nmi) return 0;
    m = 0;
    for (int i = 0; i < 4; i++)
      if (m_en[i] && m_bp[i] == ad) m[i] = 1;
    st = (m_n == 1);
    if (m_n > 0) m_n = m_n - 1;
    f = (m != 0) || st;
    if (f) begin
      m_hv = 1;
      m_step = st;
      for (int i = 3; i >= 0; i--)
        if (m[i]) m_idx = 2'(i);
      m_en = m_en & ~(m & m_os);
    end
    return f;
  endfunction

  task automatic cyc();
    @(posedge fclk);
    #1;
  endtask

  task automatic zp_pulse();
    if (imm_nmi) zp_hi++;
    zpos = 1; cyc(); zpos = 0;
  endtask

  task automatic zn_pulse();
    zneg = 1; cyc(); zneg = 0;
  endtask

  task automatic wr(input logic [3:0] ad, input logic [7:0] d);
    wr_stb = 1; wr_addr = ad; wr_data = d;
    cyc();
    wr_stb = 0;
    model_wr(ad, d);
  endtask

  // One opcode fetch; optional write in the m1_edge fclk,
  // optional in_nmi rise in the first request fclk.
  task automatic fetch(input logic [15:0] ad, input bit cw,
                       input logic [3:0] wa, input logic [7:0] wd,
                       input bit early,
                       output logic pre, output logic post,
                       output logic post2, output logic post3);
    a = ad; m1_n = 0; mreq_n = 0;
    zp_pulse();
    zn_pulse();
    pre = imm_nmi;
    if (cw) begin
      wr_stb = 1; wr_addr = wa; wr_data = wd;
    end
    cyc();
    wr_stb = 0;
    post = imm_nmi;
    if (early) in_nmi = 1;
    m1_n = 1; mreq_n = 1;
    zp_pulse();
    post2 = imm_nmi;
    zn_pulse();
    post3 = imm_nmi;
    cyc();
    a = 16'($urandom);
  endtask

  task automatic nmi_ack(output logic dropped);
    in_nmi = 1;
    cyc();
    dropped = !imm_nmi;
    repeat (3) cyc();
    in_nmi = 0;
    cyc(); cyc();
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    n_checks++;
    if (imm_nmi !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_imm: got %b want 0", imm_nmi);
    end
    rst_n = 1;
    cyc(); cyc();
    n_checks++;
    if ({hit_valid, hit_idx, hit_step, fire_tmo} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %b want 00000",
               {hit_valid, hit_idx, hit_step, fire_tmo});
    end
    n_checks++;
    if (imm_nmi !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_imm_after: got %b want 0", imm_nmi);
    end
  endtask

  task automatic test_basic();
    logic p0, p1, p2, p3, dr;
    bit e;
    wr(0, 8'h34); wr(1, 8'h12); wr(8, 8'h01);
    e = model_fetch(16'h1233, 0);
    fetch(16'h1233, 0, 0, 0, 0, p0, p1, p2, p3);
    n_checks++;
    if (p1 !== e) begin
      n_fail++;
      $display("FAIL basic_miss: imm %b want %b", p1, e);
    end
    e = model_fetch(16'h1234, 0);
    fetch(16'h1234, 0, 0, 0, 0, p0, p1, p2, p3);
    n_checks++;
    if (p0 !== 1'b0 || p1 !== e) begin
      n_fail++;
      $display("FAIL basic_hit: imm %b->%b want 0->%b", p0, p1, e);
    end
    n_checks++;
    if (hit_valid !== m_hv || hit_idx !== m_idx || hit_step !== m_step) begin
      n_fail++;
      $display("FAIL basic_status: v/i/s %b/%0d/%b want %b/%0d/%b",
               hit_valid, hit_idx, hit_step, m_hv, m_idx, m_step);
    end
    nmi_ack(dr);
    n_checks++;
    if (dr !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drop: imm still %b after in_nmi", imm_nmi);
    end
  endtask

  task automatic test_oneshot();
    logic p0, p1, p2, p3, dr;
    bit e;
    wr(10, 0);
    wr(2, 8'h00); wr(3, 8'h80); wr(4, 8'h00); wr(5, 8'h80);
    wr(8, 8'h26);
    for (int k = 0; k < 3; k++) begin
      e = model_fetch(16'h8000, 0);
      fetch(16'h8000, 0, 0, 0, 0, p0, p1, p2, p3);
      n_checks++;
      if (p1 !== e || hit_idx !== m_idx) begin
        n_fail++;
        $display("FAIL oneshot_%0d: imm %b idx %0d want %b idx %0d",
                 k, p1, hit_idx, e, m_idx);
      end
      nmi_ack(dr);
    end
  endtask

  task automatic test_step();
    logic p0, p1, p2, p3, dr;
    bit e;
    wr(8, 0); wr(10, 0); wr(9, 3);
    for (int k = 0; k < 4; k++) begin
      e = model_fetch(16'h4000 + 16'(k), 0);
      fetch(16'h4000 + 16'(k), 0, 0, 0, 0, p0, p1, p2, p3);
      n_checks++;
      if (p1 !== e || hit_step !== m_step || hit_idx !== m_idx) begin
        n_fail++;
        $display("FAIL step_%0d: imm %b step %b idx %0d want %b %b %0d",
                 k, p1, hit_step, hit_idx, e, m_step, m_idx);
      end
      if (p1) nmi_ack(dr);
    end
  endtask

  task automatic test_min_high();
    logic p0, p1, p2, p3;
    bit e;
    wr(0, 8'h34); wr(1, 8'h12); wr(8, 8'h01);
    e = model_fetch(16'h1234, 0);
    fetch(16'h1234, 0, 0, 0, 1, p0, p1, p2, p3);
    n_checks++;
    if ({p1, p2, p3} !== {e, e, 1'b0}) begin
      n_fail++;
      $display("FAIL min_high: imm seq %b%b%b want %b%b0",
               p1, p2, p3, e, e);
    end
    in_nmi = 0;
    cyc(); cyc();
  endtask

  task automatic test_timeout();
    logic p0, p1, p2, p3, dr;
    bit e;
    int k;
    zp_hi = 0;
    e = model_fetch(16'h1234, 0);
    fetch(16'h1234, 0, 0, 0, 0, p0, p1, p2, p3);
    k = 0;
    while (imm_nmi && k < 400) begin
      zp_pulse();
      cyc();
      k++;
    end
    n_checks++;
    if (imm_nmi !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_bound: imm still %b after %0d ticks", imm_nmi, k);
    end
    n_checks++;
    if (zp_hi !== TMO || p1 !== e) begin
      n_fail++;
      $display("FAIL tmo_len: %0d ticks high want %0d", zp_hi, TMO);
    end
    m_tmo = 1;
    n_checks++;
    if (fire_tmo !== m_tmo) begin
      n_fail++;
      $display("FAIL tmo_flag: got %b want 1", fire_tmo);
    end
    e = model_fetch(16'h1234, 0);
    fetch(16'h1234, 0, 0, 0, 0, p0, p1, p2, p3);
    n_checks++;
    if (p1 !== e) begin
      n_fail++;
      $display("FAIL tmo_rewatch: imm %b want %b", p1, e);
    end
    nmi_ack(dr);
    wr(10, 0);
    n_checks++;
    if (fire_tmo !== m_tmo || hit_valid !== m_hv) begin
      n_fail++;
      $display("FAIL tmo_clear: tmo %b valid %b want %b %b",
               fire_tmo, hit_valid, m_tmo, m_hv);
    end
  endtask

  task automatic test_nmi_block();
    logic p0, p1, p2, p3, dr;
    bit e;
    wr(0, 8'h66); wr(1, 8'h00); wr(8, 8'h01);
    in_nmi = 1;
    e = model_fetch(16'h0066, 1);
    fetch(16'h0066, 0, 0, 0, 0, p0, p1, p2, p3);
    in_nmi = 0;
    n_checks++;
    if (p1 !== e) begin
      n_fail++;
      $display("FAIL nmi_block: imm %b want %b", p1, e);
    end
    e = model_fetch(16'h0200, 0);
    model_wr(9, 5);
    fetch(16'h0200, 1, 9, 5, 0, p0, p1, p2, p3);
    n_checks++;
    if (p1 !== e) begin
      n_fail++;
      $display("FAIL nwr_edge: imm %b want %b", p1, e);
    end
    for (int k = 0; k < 7; k++) begin
      bit nm;
      nm = (k < 2);
      in_nmi = nm;
      e = model_fetch(16'h0300, nm);
      fetch(16'h0300, 0, 0, 0, 0, p0, p1, p2, p3);
      in_nmi = 0;
      n_checks++;
      if (p1 !== e) begin
        n_fail++;
        $display("FAIL nstep_%0d: imm %b want %b", k, p1, e);
      end
      if (p1) nmi_ack(dr);
    end
  endtask

  task automatic test_reset_fire();
    logic p0, p1, p2, p3;
    bit e;
    e = model_fetch(16'h0066, 0);
    fetch(16'h0066, 0, 0, 0, 0, p0, p1, p2, p3);
    n_checks++;
    if (p1 !== e) begin
      n_fail++;
      $display("FAIL rst_prefire: imm %b want %b", p1, e);
    end
    #2;
    rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (imm_nmi !== 1'b0 || hit_valid !== m_hv || hit_idx !== m_idx) begin
      n_fail++;
      $display("FAIL rst_mid_fire: imm %b valid %b idx %0d want 0 0 0",
               imm_nmi, hit_valid, hit_idx);
    end
    cyc(); cyc();
    rst_n = 1;
    cyc();
    e = model_fetch(16'h0066, 0);
    fetch(16'h0066, 0, 0, 0, 0, p0, p1, p2, p3);
    n_checks++;
    if (p1 !== e) begin
      n_fail++;
      $display("FAIL rst_nofire: imm %b want %b", p1, e);
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [4];
    logic p0, p1, p2, p3, dr;
    bit e;
    bit nm;
    int r;
    int j;
    pool[0] = 16'h1000; pool[1] = 16'h1001;
    pool[2] = 16'h2000; pool[3] = 16'hffff;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        j = $urandom_range(0, 3);
        wr(4'(2 * j), pool[$urandom_range(0, 3)][7:0]);
        wr(4'(2 * j + 1), pool[$urandom_range(0, 3)][15:8]);
      end else if (r == 2) begin
        wr(8, 8'($urandom));
      end else if (r == 3) begin
        wr(9, 8'($urandom_range(0, 3)));
      end else if (r == 4) begin
        wr(10, 0);
      end else begin
        j = $urandom_range(0, 3);
        nm = ($urandom_range(0, 4) == 0);
        in_nmi = nm;
        e = model_fetch(pool[j], nm);
        fetch(pool[j], 0, 0, 0, 0, p0, p1, p2, p3);
        in_nmi = 0;
        n_checks++;
        if (p1 !== e || hit_valid !== m_hv) begin
          n_fail++;
          $display("FAIL rnd_fire_%0d: imm %b valid %b want %b %b",
                   it, p1, hit_valid, e, m_hv);
        end
        if (e) begin
          n_checks++;
          if (hit_idx !== m_idx || hit_step !== m_step) begin
            n_fail++;
            $display("FAIL rnd_hit_%0d: idx %0d step %b want %0d %b",
                     it, hit_idx, hit_step, m_idx, m_step);
          end
        end
        if (p1) begin
          nmi_ack(dr);
          n_checks++;
          if (dr !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_drop_%0d: imm not dropped", it);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; zp_hi = 0;
    rst_n = 0; zpos = 0; zneg = 0;
    m1_n = 1; mreq_n = 1; a = 16'h0;
    wr_stb = 0; wr_addr = 0; wr_data = 0; in_nmi = 0;
    model_reset();
    test_reset();
    test_basic();
    test_oneshot();
    test_step();
    test_min_high();
    test_timeout();
    test_nmi_block();
    test_reset_fire();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
